// File: rtl/ysyx_25040111_lsu_pkg.sv
// Shared LSU definitions: widths, op/size encodings, FSM state codes and the alignment check.
// The alignment check is only used when YSYX_25040111_LSU_MISALIGN_EN is defined.
package ysyx_25040111_lsu_pkg;

  localparam int XLEN = 32;
  localparam int RD_W = 5;

  localparam logic [1:0] LSU_OP_NONE  = 2'b00;
  localparam logic [1:0] LSU_OP_LOAD  = 2'b01;
  localparam logic [1:0] LSU_OP_STORE = 2'b10;

  localparam logic [1:0] LSU_SZ_BYTE = 2'b00;
  localparam logic [1:0] LSU_SZ_HALF = 2'b01;
  localparam logic [1:0] LSU_SZ_WORD = 2'b10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Size code 11 behaves as a word access.
  function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      LSU_SZ_BYTE: lsu_misaligned = 1'b0;
      LSU_SZ_HALF: lsu_misaligned = lo[0];
      default:     lsu_misaligned = |lo;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_25040111_lsu_if.sv
// Simple req/resp memory bus between the LSU (master) and memory (slave).
interface ysyx_25040111_lsu_if;
  import ysyx_25040111_lsu_pkg::*;

  logic            mem_req_valid;
  logic            mem_req_ready;
  logic            mem_wen;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [3:0]      mem_wstrb;
  logic            mem_resp_valid;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wstrb,
    input  mem_req_ready, mem_resp_valid, mem_rdata
  );

  modport slave (
    input  mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wstrb,
    output mem_req_ready, mem_resp_valid, mem_rdata
  );

endinterface

// File: rtl/ysyx_25040111_lsu_align.sv
// Combinational lane logic: store strobe/data placement and load extract with sign/zero extension.
module ysyx_25040111_lsu_align
  import ysyx_25040111_lsu_pkg::*;
(
  input  logic [1:0]      size,
  input  logic            is_unsigned,
  input  logic [1:0]      lo,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      strb,
  output logic [XLEN-1:0] wlane,
  output logic [XLEN-1:0] rext
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = 8'(rdata >> {lo, 3'b000});
  assign half_v = 16'(rdata >> {lo[1], 4'b0000});

  // Without the misalign check, a half ignores lo[0] and a word always uses lane 0.
  always_comb begin
    strb  = 4'b1111;
    wlane = wdata;
    rext  = rdata;
    case (size)
      LSU_SZ_BYTE: begin
        strb  = 4'b0001 << lo;
        wlane = {4{wdata[7:0]}};
        rext  = {{24{~is_unsigned & byte_v[7]}}, byte_v};
      end
      LSU_SZ_HALF: begin
        strb  = 4'b0011 << {lo[1], 1'b0};
        wlane = {2{wdata[15:0]}};
        rext  = {{16{~is_unsigned & half_v[15]}}, half_v};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ysyx_25040111_lsu.sv
// Load/store unit: accepts one EXU result, runs at most one bus transaction, hands the result to the WBU.
// Optional misaligned-access trap enabled by defining YSYX_25040111_LSU_MISALIGN_EN.
module ysyx_25040111_lsu
  import ysyx_25040111_lsu_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [1:0]                  in_op,
  input  logic [1:0]                  in_size,
  input  logic                        in_unsigned,
  input  logic [XLEN-1:0]             in_addr,
  input  logic [XLEN-1:0]             in_wdata,
  input  logic [RD_W-1:0]             in_rd,
  ysyx_25040111_lsu_if.master         mem,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [XLEN-1:0]             out_data,
  output logic [RD_W-1:0]             out_rd,
  output logic                        out_err
);

  logic [1:0]      state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [RD_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            err_q, err_d;

  logic            misalign;
  logic            is_store;
  logic            is_mem_in;
  logic [3:0]      strb;
  logic [XLEN-1:0] wlane;
  logic [XLEN-1:0] rext;

`ifdef YSYX_25040111_LSU_MISALIGN_EN
  assign misalign = lsu_misaligned(in_size, in_addr[1:0]);
`else
  assign misalign = 1'b0;
`endif

  assign is_mem_in = (in_op == LSU_OP_LOAD) || (in_op == LSU_OP_STORE);
  assign is_store  = (op_q == LSU_OP_STORE);

  ysyx_25040111_lsu_align u_align (
    .size        (size_q),
    .is_unsigned (uns_q),
    .lo          (addr_q[1:0]),
    .wdata       (wdata_q),
    .rdata       (mem.mem_rdata),
    .strb        (strb),
    .wlane       (wlane),
    .rext        (rext)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d    = in_op;
          size_d  = in_size;
          uns_d   = in_unsigned;
          addr_d  = in_addr;
          wdata_d = in_wdata;
          rd_d    = in_rd;
          err_d   = is_mem_in & misalign;
          // Passthrough and trapped accesses both report the EXU value directly.
          data_d  = in_addr;
          state_d = (is_mem_in && !misalign) ? ST_REQ : ST_DONE;
        end
      end
      ST_REQ:  if (mem.mem_req_ready) state_d = ST_WAIT;
      ST_WAIT: begin
        if (mem.mem_resp_valid) begin
          data_d  = is_store ? '0 : rext;
          state_d = ST_DONE;
        end
      end
      default: if (out_ready) state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= LSU_OP_NONE;
      size_q  <= LSU_SZ_BYTE;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign in_ready          = (state_q == ST_IDLE);
  assign mem.mem_req_valid = (state_q == ST_REQ);
  assign mem.mem_wen       = (state_q == ST_REQ) && is_store;
  assign mem.mem_addr      = {addr_q[XLEN-1:2], 2'b00};
  assign mem.mem_wdata     = wlane;
  assign mem.mem_wstrb     = ((state_q == ST_REQ) && is_store) ? strb : 4'b0000;
  assign out_valid         = (state_q == ST_DONE);
  assign out_data          = data_q;
  assign out_rd            = rd_q;
  assign out_err           = err_q;

endmodule

// File: tb/tb_ysyx_25040111_lsu.sv
// Table-driven LSU bench with a result scoreboard; follows YSYX_25040111_LSU_MISALIGN_EN like the RTL.
module tb_ysyx_25040111_lsu;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [1:0]  in_size;
  logic        in_unsigned;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        out_err;

  ysyx_25040111_lsu_if bus ();

  ysyx_25040111_lsu dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_size     (in_size),
    .in_unsigned (in_unsigned),
    .in_addr     (in_addr),
    .in_wdata    (in_wdata),
    .in_rd       (in_rd),
    .mem         (bus.master),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_rd      (out_rd),
    .out_err     (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic        exp_req;
    logic        exp_wen;
    logic [31:0] exp_maddr;
    logic [3:0]  exp_strb;
    logic [31:0] exp_mwdata;
    logic [31:0] exp_data;
    logic        exp_err;
    int          req_stall;
    int          out_stall;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        err;
  } exp_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];
  exp_t sb [$];
  int   checks = 0;
  int   passed = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
  endtask

  // Drives one transaction, acts as the memory, and compares against the table and scoreboard.
  task automatic applyStimulus(input vec_t v);
    int   cyc = 0;
    int   rstall = 0;
    int   ostall = 0;
    bit   req_seen = 0;
    bit   resp_pending = 0;
    bit   done = 0;
    exp_t e;
    exp_t got;
    @(negedge clk);
    checkOutput("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_valid    = 1'b1;
    in_op       = v.op;
    in_size     = v.size;
    in_unsigned = v.uns;
    in_addr     = v.addr;
    in_wdata    = v.wdata;
    in_rd       = v.rd;
    e.data = v.exp_data;
    e.rd   = v.rd;
    e.err  = v.exp_err;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    while (!done && cyc < 60) begin
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b0;
      out_ready          = 1'b0;
      checkOutput("in_ready_busy", {31'd0, in_ready}, 32'd0);
      if (resp_pending) begin
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = v.rdata;
        resp_pending       = 0;
      end
      if (bus.mem_req_valid) begin
        req_seen = 1;
        checkOutput("mem_addr", bus.mem_addr, v.exp_maddr);
        checkOutput("mem_wen", {31'd0, bus.mem_wen}, {31'd0, v.exp_wen});
        checkOutput("mem_wstrb", {28'd0, bus.mem_wstrb}, {28'd0, v.exp_strb});
        if (v.exp_wen) checkOutput("mem_wdata", bus.mem_wdata, v.exp_mwdata);
        if (rstall < v.req_stall) rstall++;
        else begin
          bus.mem_req_ready = 1'b1;
          resp_pending      = 1;
        end
      end
      if (out_valid) begin
        if (ostall < v.out_stall) begin
          ostall++;
          checkOutput("out_data_held", out_data, v.exp_data);
          checkOutput("out_rd_held", {27'd0, out_rd}, {27'd0, v.rd});
        end else begin
          out_ready = 1'b1;
          if (sb.size() == 0) begin
            checkOutput("scoreboard_empty", 32'd1, 32'd0);
          end else begin
            got = sb.pop_front();
            checkOutput("out_data", out_data, got.data);
            checkOutput("out_rd", {27'd0, out_rd}, {27'd0, got.rd});
            checkOutput("out_err", {31'd0, out_err}, {31'd0, got.err});
          end
          done = 1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    out_ready          = 1'b0;
    if (!done) begin
      checkOutput("txn_timeout", 32'd1, 32'd0);
      void'(sb.pop_front());
    end
    checkOutput("req_issued", {31'd0, req_seen}, {31'd0, v.exp_req});
    if (v.req_stall > 0) checkOutput("req_stall_cycles", rstall, v.req_stall);
    if (v.out_stall > 0) checkOutput("out_stall_cycles", ostall, v.out_stall);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    checkOutput({tag, "_req_valid"}, {31'd0, bus.mem_req_valid}, 32'd0);
    checkOutput({tag, "_wen"}, {31'd0, bus.mem_wen}, 32'd0);
    checkOutput({tag, "_wstrb"}, {28'd0, bus.mem_wstrb}, 32'd0);
    checkOutput({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
    checkOutput({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    checkOutput({tag, "_out_err"}, {31'd0, out_err}, 32'd0);
    checkOutput({tag, "_out_data"}, out_data, 32'd0);
    checkOutput({tag, "_out_rd"}, {27'd0, out_rd}, 32'd0);
  endtask

  initial begin
    //          op     sz     u     addr          wdata         rd     rdata         req   wen   maddr         strb     mwdata        data          err  rs pr
    vecs[0]  = '{2'b00, 2'b10, 1'b0, 32'h00001234, 32'h0,        5'd5,  32'h0,        1'b0, 1'b0, 32'h0,        4'b0000, 32'h0,        32'h00001234, 1'b0, 0, 0};
    vecs[1]  = '{2'b01, 2'b00, 1'b0, 32'h80000003, 32'h0,        5'd1,  32'h80FF0000, 1'b1, 1'b0, 32'h80000000, 4'b0000, 32'h0,        32'hFFFFFF80, 1'b0, 0, 0};
    vecs[2]  = '{2'b01, 2'b00, 1'b1, 32'h80000003, 32'h0,        5'd2,  32'h80FF0000, 1'b1, 1'b0, 32'h80000000, 4'b0000, 32'h0,        32'h00000080, 1'b0, 0, 0};
    vecs[3]  = '{2'b10, 2'b01, 1'b0, 32'h80000002, 32'hDEADBEEF, 5'd3,  32'h0,        1'b1, 1'b1, 32'h80000000, 4'b1100, 32'hBEEFBEEF, 32'h00000000, 1'b0, 0, 0};
    vecs[4]  = '{2'b10, 2'b01, 1'b0, 32'h80000002, 32'hDEADBEEF, 5'd4,  32'h0,        1'b1, 1'b1, 32'h80000000, 4'b1100, 32'hBEEFBEEF, 32'h00000000, 1'b0, 3, 2};
    vecs[5]  = '{2'b01, 2'b01, 1'b0, 32'h80000002, 32'h0,        5'd6,  32'h80011234, 1'b1, 1'b0, 32'h80000000, 4'b0000, 32'h0,        32'hFFFF8001, 1'b0, 0, 0};
    vecs[6]  = '{2'b01, 2'b01, 1'b1, 32'h80000000, 32'h0,        5'd7,  32'h1234ABCD, 1'b1, 1'b0, 32'h80000000, 4'b0000, 32'h0,        32'h0000ABCD, 1'b0, 1, 1};
    vecs[7]  = '{2'b10, 2'b00, 1'b0, 32'h80000001, 32'h000000A5, 5'd8,  32'h0,        1'b1, 1'b1, 32'h80000000, 4'b0010, 32'hA5A5A5A5, 32'h00000000, 1'b0, 0, 0};
    vecs[8]  = '{2'b10, 2'b10, 1'b0, 32'h80000004, 32'h12345678, 5'd9,  32'h0,        1'b1, 1'b1, 32'h80000004, 4'b1111, 32'h12345678, 32'h00000000, 1'b0, 0, 0};
    vecs[9]  = '{2'b11, 2'b10, 1'b0, 32'h00000055, 32'h0,        5'd31, 32'h0,        1'b0, 1'b0, 32'h0,        4'b0000, 32'h0,        32'h00000055, 1'b0, 0, 0};
    vecs[10] = '{2'b01, 2'b11, 1'b0, 32'h80000010, 32'h0,        5'd10, 32'h01020304, 1'b1, 1'b0, 32'h80000010, 4'b0000, 32'h0,        32'h01020304, 1'b0, 0, 0};
`ifdef YSYX_25040111_LSU_MISALIGN_EN
    vecs[11] = '{2'b01, 2'b10, 1'b0, 32'h80000001, 32'h0,        5'd11, 32'h11223344, 1'b0, 1'b0, 32'h0,        4'b0000, 32'h0,        32'h80000001, 1'b1, 0, 0};
`else
    vecs[11] = '{2'b01, 2'b10, 1'b0, 32'h80000001, 32'h0,        5'd11, 32'h11223344, 1'b1, 1'b0, 32'h80000000, 4'b0000, 32'h0,        32'h11223344, 1'b0, 0, 0};
`endif

    rst_n              = 1'b0;
    in_valid           = 1'b0;
    in_op              = 2'b00;
    in_size            = 2'b00;
    in_unsigned        = 1'b0;
    in_addr            = '0;
    in_wdata           = '0;
    in_rd              = '0;
    out_ready          = 1'b0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = '0;

    repeat (2) @(negedge clk);
    checkResetOutputs("reset");
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) applyStimulus(vecs[i]);

    // Reset while the load waits for its response; a late response must be ignored.
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = 2'b01;
    in_size  = 2'b10;
    in_addr  = 32'h80000020;
    in_rd    = 5'd12;
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("rst_seq_req", {31'd0, bus.mem_req_valid}, 32'd1);
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    checkOutput("rst_seq_wait", {31'd0, in_ready | bus.mem_req_valid | out_valid}, 32'd0);
    rst_n = 1'b0;
    #1;
    checkResetOutputs("async_reset");
    @(negedge clk);
    rst_n              = 1'b1;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'hBADBAD00;
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    checkResetOutputs("late_resp");
    applyStimulus(vecs[0]);
    applyStimulus(vecs[3]);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
